// File: rtl/axis_frame_header.sv
// -----------------------------------------------------------------------------
// axis_frame_header
//
// Wraps each AXI-Stream input packet into one output frame:
//   header word  : {zeros, magic[15:0], seq[15:0]}
//   payload      : input beats passed through unchanged
//   trailer word : payload beat count (saturating), zero-extended, tlast=1
//
// Ports
//   aclk, aresetn        clock; synchronous active-low reset
//   cfg_enbl             allow new frames to start (sampled only in IDLE)
//   cfg_magic[15:0]      tag copied into the header at frame start
//   s_axis_*             upstream stream (tdata/tvalid/tlast in, tready out)
//   m_axis_*             downstream stream (tdata/tvalid/tlast out, tready in)
//   sts_seq[15:0]        frames completed, modulo 2^16
//   sts_len[CNTR_WIDTH]  payload length of the last completed frame
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no frame in flight, waiting for cfg_enbl and s_axis_tvalid
// HEADER  | presenting header word, upstream held off
// DATA    | upstream and downstream connected, beats counted
// TRAILER | presenting beat count with tlast, upstream held off
// -----------------------------------------------------------------------------
module axis_frame_header #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNTR_WIDTH       = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        cfg_enbl,
  input  logic [15:0]                 cfg_magic,
  output logic                        s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        s_axis_tlast,
  input  logic                        m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  output logic [15:0]                 sts_seq,
  output logic [CNTR_WIDTH-1:0]       sts_len
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_DATA    = 2'd2,
    ST_TRAILER = 2'd3
  } state_t;

  localparam logic [CNTR_WIDTH-1:0] CNT_MAX = '1;

  state_t                  state_q;
  logic [15:0]             magic_q;
  logic [15:0]             seq_q;
  logic [CNTR_WIDTH-1:0]   cnt_q;
  logic [CNTR_WIDTH-1:0]   len_q;
  logic                    valid_q;
  logic                    last_q;

  logic                    beat_xfer;
  logic [CNTR_WIDTH-1:0]   cnt_next;
  logic [AXIS_TDATA_WIDTH-1:0] hdr_word;
  logic [AXIS_TDATA_WIDTH-1:0] trl_word;

  assign beat_xfer = (state_q == ST_DATA) && s_axis_tvalid && m_axis_tready;

  // Beat counter saturates instead of wrapping so an oversized packet
  // reports the maximum rather than a misleading small length.
  assign cnt_next = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNTR_WIDTH'(1);

  // Header and trailer are built only from registers, so both words stay
  // stable while the downstream stalls.
  always_comb begin
    hdr_word        = '0;
    hdr_word[31:16] = magic_q;
    hdr_word[15:0]  = seq_q;
  end

  always_comb begin
    trl_word                   = '0;
    trl_word[CNTR_WIDTH-1:0]   = cnt_q;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      magic_q <= '0;
      seq_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cfg_enbl && s_axis_tvalid) begin
            magic_q <= cfg_magic;
            valid_q <= 1'b1;
            last_q  <= 1'b0;
            state_q <= ST_HEADER;
          end
        end
        ST_HEADER: begin
          if (m_axis_tready) begin
            valid_q <= 1'b0;
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (beat_xfer) begin
            cnt_q <= cnt_next;
            if (s_axis_tlast) begin
              valid_q <= 1'b1;
              last_q  <= 1'b1;
              state_q <= ST_TRAILER;
            end
          end
        end
        ST_TRAILER: begin
          if (m_axis_tready) begin
            len_q   <= cnt_q;
            seq_q   <= seq_q + 16'd1;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Output steering: DATA is a pure combinational pass-through, the other
  // states present registered values. Handshake outputs are forced low for
  // as long as reset is held, not only from the next edge on.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tvalid = valid_q;
    m_axis_tlast  = last_q;
    s_axis_tready = 1'b0;
    case (state_q)
      ST_HEADER:  m_axis_tdata = hdr_word;
      ST_DATA: begin
        m_axis_tdata  = s_axis_tdata;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tlast  = 1'b0;
        s_axis_tready = m_axis_tready;
      end
      ST_TRAILER: m_axis_tdata = trl_word;
      default:    m_axis_tdata = '0;
    endcase
    if (!aresetn) begin
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      s_axis_tready = 1'b0;
    end
  end

  assign sts_seq = seq_q;
  assign sts_len = len_q;

endmodule

// File: doc/axis_frame_header.md
AXIS_FRAME_HEADER -- requirements
Module: axis_frame_header

Interface
REQ-001 The block SHALL have parameter AXIS_TDATA_WIDTH, default 32, stream data width; legal values are 32 or greater.
REQ-002 The block SHALL have parameter CNTR_WIDTH, default 16, payload beat counter width; legal range is 1 to AXIS_TDATA_WIDTH.
REQ-003 Port aclk SHALL be an input, 1 bit wide: the clock; all logic is sampled on its rising edge.
REQ-004 Port aresetn SHALL be an input, 1 bit wide: the reset, synchronous and active-low.
REQ-005 Port cfg_enbl SHALL be an input, 1 bit wide: when high, the block may start new frames.
REQ-006 Port cfg_magic SHALL be an input, 16 bits wide: the tag placed in the header word.
REQ-007 Port s_axis_tready SHALL be an output, 1 bit wide: slave ready.
REQ-008 Port s_axis_tdata SHALL be an input, AXIS_TDATA_WIDTH bits wide: slave data.
REQ-009 Port s_axis_tvalid SHALL be an input, 1 bit wide: slave valid.
REQ-010 Port s_axis_tlast SHALL be an input, 1 bit wide: marks the last beat of the payload packet.
REQ-011 Port m_axis_tready SHALL be an input, 1 bit wide: master ready.
REQ-012 Port m_axis_tdata SHALL be an output, AXIS_TDATA_WIDTH bits wide: master data.
REQ-013 Port m_axis_tvalid SHALL be an output, 1 bit wide: master valid.
REQ-014 Port m_axis_tlast SHALL be an output, 1 bit wide: marks the last beat of the output frame.
REQ-015 Port sts_seq SHALL be an output, 16 bits wide: the number of frames completed, modulo 2^16.
REQ-016 Port sts_len SHALL be an output, CNTR_WIDTH bits wide: the payload length of the last completed frame.

Function
REQ-017 The block SHALL wrap each input packet as one output frame: a header word, then the payload beats unchanged, then a trailer word.
REQ-018 The block SHALL implement four states: IDLE, HEADER, DATA and TRAILER.
REQ-019 In IDLE, the block SHALL drive s_axis_tready=0 and m_axis_tvalid=0; when cfg_enbl=1 and s_axis_tvalid=1 it SHALL move to HEADER on the next cycle and capture cfg_magic into a holding register.
REQ-020 In HEADER, the block SHALL drive m_axis_tvalid=1, m_axis_tlast=0 and s_axis_tready=0.
REQ-021 The header word SHALL contain the captured magic in bits [31:16] and the sequence counter in bits [15:0]; all bits above bit 31 SHALL be zero.
REQ-022 The block SHALL leave HEADER for DATA on the first cycle in which m_axis_tready=1.
REQ-023 In DATA, the block SHALL connect the streams combinationally: m_axis_tdata=s_axis_tdata, m_axis_tvalid=s_axis_tvalid, s_axis_tready=m_axis_tready, m_axis_tlast=0.
REQ-024 In DATA, the beat counter SHALL increment on every transfer (s_axis_tvalid and m_axis_tready both high) and SHALL saturate at 2^CNTR_WIDTH-1, never wrapping.
REQ-025 A DATA-state transfer with s_axis_tlast=1 SHALL be counted, and the block SHALL move to TRAILER on the next cycle.
REQ-026 In TRAILER, the block SHALL drive m_axis_tvalid=1, m_axis_tlast=1 and s_axis_tready=0; the data word SHALL be the beat count, zero-extended.
REQ-027 When the trailer transfers (m_axis_tready=1), the block SHALL copy the beat count to sts_len, increment the sequence counter (wrapping from 0xFFFF to 0x0000), clear the beat counter, and return to IDLE.
REQ-028 While m_axis_tvalid=1 and m_axis_tready=0, the block SHALL hold m_axis_tdata and m_axis_tlast stable in HEADER and TRAILER; in DATA they follow the upstream, which keeps its beat stable under AXIS rules.
REQ-029 cfg_enbl SHALL be sampled only in IDLE; deasserting it mid-frame SHALL NOT truncate the current frame.
REQ-030 Changes to cfg_magic after HEADER entry SHALL NOT affect the current header.
REQ-031 sts_seq SHALL always equal the sequence counter value.
REQ-032 Latency from s_axis_tvalid rising in IDLE to header m_axis_tvalid SHALL be 1 cycle.
REQ-033 Back-to-back frames SHALL use one IDLE cycle between the trailer transfer and the next header.

Reset
REQ-034 While aresetn=0, the block SHALL set the state to IDLE, the sequence counter, beat counter, sts_len and magic register to 0, and hold s_axis_tready, m_axis_tvalid and m_axis_tlast at 0.
REQ-035 Reset asserted mid-frame SHALL abandon the frame with no trailer emitted; the first frame after reset SHALL carry sequence number 0.

Verification
REQ-036 The bench SHALL cover: cfg_magic=0xA5A5, 4-beat packet D0..D3, m_axis_tready=1 -> output 0xA5A50000, D0..D3, 0x00000004 with tlast on the trailer only; sts_seq=1, sts_len=4.
REQ-037 The bench SHALL cover: 1-beat packet with tlast=1 -> header, payload, trailer=1; exactly 3 output beats.
REQ-038 The bench SHALL cover: m_axis_tready toggling randomly over a 10-beat packet -> header and trailer held stable while stalled, all 10 payload beats in order, trailer=10.
REQ-039 The bench SHALL cover: CNTR_WIDTH=4 with an 20-beat packet -> trailer=15 (saturated); the next frame's count starts from 0.
REQ-040 The bench SHALL cover: 65537 frames -> the header sequence field wraps from 0xFFFF to 0x0000.
REQ-041 The bench SHALL cover: aresetn pulsed low during DATA -> all outputs 0 in the next cycle, no tlast emitted, next header sequence=0.
